// File: rtl/fp64_pkg.sv
// Shared constants and pipeline payload types for the FP64 normalise/pack back end.
package fp64_pkg;
    localparam int FP64_BIAS    = 1023;
    localparam int FP64_EXP_MAX = 2047;
    localparam int FP64_FRAC_W  = 52;
    localparam int FP64_EXP_W   = 13;   // biased exponent width carried through the pipe
    localparam int FP64_MANT_W  = 64;

    typedef struct packed {
        logic                   sign;
        logic [10:0]            exp;
        logic [FP64_FRAC_W-1:0] frac;
    } fp64_t;

    // count stage: raw input plus its leading-zero count
    typedef struct packed {
        logic                   sign;
        logic                   zero;
        logic [FP64_EXP_W-1:0]  exp;
        logic [5:0]             lz;
        logic [FP64_MANT_W-1:0] mant;
    } s1_t;

    // shift stage: left-justified magnitude, exponent one bit wider so it cannot wrap
    typedef struct packed {
        logic                   sign;
        logic                   zero;
        logic [FP64_EXP_W:0]    e;
        logic [FP64_MANT_W-1:0] m;
    } s2_t;
endpackage

// File: rtl/fp64_normalize_pack_clz.sv
// 64-bit leading-zero counter (combinational). An all-zero input yields 0;
// callers flag zero separately.
module fp64_normalize_pack_clz (
    input  logic [63:0] a,
    output logic [5:0]  lz
);
    logic found;

    // scan from the MSB, counting zeros until the first set bit
    always_comb begin
        lz    = 6'd0;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found) begin
                if (a[i]) found = 1'b1;
                else      lz    = lz + 6'd1;
            end
        end
    end
endmodule

// File: rtl/fp64_normalize_pack.sv
// FP64 back end: count leading zeros, left-justify, round-to-nearest-even, pack.
// Three-stage pipeline with a single global stall (adv).
// Optional: define FP64_DENORM_EN to produce subnormals instead of flushing to zero.
module fp64_normalize_pack
    import fp64_pkg::*;
#(
    parameter int EXP_W  = FP64_EXP_W,
    parameter int MANT_W = FP64_MANT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data
);
    localparam int STAGES = 3;
    localparam int EW     = FP64_EXP_W;
    localparam int EW3    = EW + 2;     // room for the rounding carry on top of the shifted exponent
    localparam logic signed [EW3-1:0] E_ONE = EW3'(1);
    localparam logic signed [EW3-1:0] E_MAX = EW3'(FP64_EXP_MAX);

    logic              adv;
    logic [STAGES:1]   vld_pipe;
    logic [5:0]        lz;
    s1_t               s1_d, s1_q;
    s2_t               s2_q;
    logic signed [EW:0] e2;
    fp64_t             res;

    assign adv       = !vld_pipe[STAGES] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    fp64_normalize_pack_clz u_clz (
        .a  (in_mant),
        .lz (lz)
    );

    assign s1_d = '{sign: in_sign, zero: (in_mant == '0), exp: in_exp, lz: lz, mant: in_mant};

    // exponent after normalisation, one bit wider than the input so it cannot wrap
    assign e2 = $signed({s1_q.exp[EW-1], s1_q.exp}) - $signed({{(EW-5){1'b0}}, s1_q.lz});

    // valid shift register; bubbles travel with the data
    always_ff @(posedge clk) begin
        if (rst)      vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // payload registers for the count and shift stages
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_q      <= s1_d;
            s2_q.sign <= s1_q.sign;
            s2_q.zero <= s1_q.zero;
            s2_q.e    <= e2;
            s2_q.m    <= s1_q.mant << s1_q.lz;
        end
    end

    logic signed [EW3-1:0] e3, e_n;
    logic [52:0]           kept, kept_n;
    logic [53:0]           rnd;
    logic                  g, st, up;
`ifdef FP64_DENORM_EN
    logic signed [EW3-1:0] sh_full;
    logic [5:0]            sh;
    logic [63:0]           m_sh;
    logic [52:0]           dk, dr;
    logic                  lost, dg, ds, dup;
`endif

    // round and pack; underflow is decided on the pre-round exponent, overflow after carry
    always_comb begin
        e3     = $signed({s2_q.e[EW], s2_q.e});
        kept   = s2_q.m[63:11];
        g      = s2_q.m[10];
        st     = |s2_q.m[9:0];
        up     = g & (st | kept[0]);
        rnd    = {1'b0, kept} + {53'd0, up};
        kept_n = rnd[53] ? 53'h10_0000_0000_0000 : rnd[52:0];
        e_n    = rnd[53] ? e3 + E_ONE : e3;
`ifdef FP64_DENORM_EN
        sh_full = E_ONE - e3;
        sh      = (sh_full > EW3'(54)) ? 6'd54 : sh_full[5:0];
        m_sh    = s2_q.m >> sh;
        lost    = |(s2_q.m & ~({64{1'b1}} << sh));
        dk      = m_sh[63:11];
        dg      = m_sh[10];
        ds      = (|m_sh[9:0]) | lost;
        dup     = dg & (ds | dk[0]);
        dr      = dk + {52'd0, dup};
`endif
        if (s2_q.zero)
            res = '{sign: s2_q.sign, exp: 11'd0, frac: '0};
        else if (e_n >= E_MAX)
            res = '{sign: s2_q.sign, exp: 11'h7FF, frac: '0};
        else if (e3 < E_ONE)
`ifdef FP64_DENORM_EN
            res = '{sign: s2_q.sign, exp: {10'd0, dr[52]}, frac: dr[51:0]};
`else
            res = '{sign: s2_q.sign, exp: 11'd0, frac: '0};
`endif
        else
            res = '{sign: s2_q.sign, exp: e_n[10:0], frac: kept_n[51:0]};
    end

    // output register; holds while downstream stalls
    always_ff @(posedge clk) begin
        if (rst)                    out_data <= '0;
        else if (adv & vld_pipe[2]) out_data <= res;
    end
endmodule

// File: tb/tb_fp64_normalize_pack.sv
// Directed self-checking bench for fp64_normalize_pack (honours FP64_DENORM_EN).
module tb_fp64_normalize_pack;
    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_sign;
    logic signed [12:0] in_exp;
    logic [63:0]        in_mant;
    logic               out_valid, out_ready;
    logic [63:0]        out_data;

    int n_tests = 0;
    int n_fail  = 0;

    fp64_normalize_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // single beat into an idle pipe; checks latency and packed value
    task automatic run_vec(input string tag, input logic s, input logic [12:0] e,
                           input logic [63:0] m, input logic [63:0] want);
        int lat;
        bit seen;
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        tick();
        in_valid = 1'b0;
        lat = 1; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin tick(); lat++; end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk(tag, out_data, want);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx, got, cyc, cnt;
        bit acc;
        logic [63:0] w;
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;

        run_vec("one",      0, 13'd1023, 64'h8000_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        run_vec("lz6_rup",  0, 13'd1029, 64'h02FF_FFFF_FFFF_FFFF, 64'h3FF8_0000_0000_0000);
        run_vec("carry",    0, 13'd1023, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000);
        run_vec("neg_zero", 1, 13'd1023, 64'h0,                   64'h8000_0000_0000_0000);
        run_vec("inf",      0, 13'd2047, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000);
        run_vec("inf_lz",   0, 13'd2048, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_0000);
        run_vec("max_norm", 0, 13'd2046, 64'h8000_0000_0000_0000, 64'h7FE0_0000_0000_0000);
        run_vec("lz63_neg", 1, 13'd1024, 64'h1,                   64'hBC10_0000_0000_0000);
        run_vec("tie_even", 0, 13'd1023, 64'h8000_0000_0000_0400, 64'h3FF0_0000_0000_0000);
        run_vec("tie_odd",  0, 13'd1023, 64'h8000_0000_0000_0C00, 64'h3FF0_0000_0000_0002);
`ifdef FP64_DENORM_EN
        run_vec("uflow",    0, 13'd0,    64'h8000_0000_0000_0000, 64'h0008_0000_0000_0000);
        run_vec("uflow_lz", 0, 13'd1,    64'h4000_0000_0000_0000, 64'h0008_0000_0000_0000);
`else
        run_vec("uflow",    0, 13'd0,    64'h8000_0000_0000_0000, 64'h0);
        run_vec("uflow_lz", 0, 13'd1,    64'h4000_0000_0000_0000, 64'h0);
`endif

        // backpressure: out_ready low for 5 cycles while streaming 6 beats
        idx = 0; got = 0; cyc = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 13'd1000; in_mant = 64'h8000_0000_0000_0000;
        while (got < 6 && cyc < 100) begin
            @(negedge clk);
            if (cyc == 2) chk("bp_in_ready_2", in_ready, 1);
            if (cyc == 3) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
            end
            if (cyc == 4) chk("bp_hold_data", out_data, 64'(1000) << 52);
            if (out_valid && out_ready) begin
                w = 64'(1000 + got) << 52;
                chk($sformatf("bp_beat%0d", got), out_data, w);
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) idx++;
            in_valid  = (idx < 6);
            in_exp    = 13'(1000 + idx);
            out_ready = (cyc >= 5);
        end
        in_valid = 1'b0;
        chk("bp_all_in", 64'(idx), 64'd6);
        chk("bp_all_out", 64'(got), 64'd6);
        repeat (2) begin
            @(negedge clk);
            chk("bp_no_extra", out_valid, 0);
            tick();
        end

        // reset with two beats in flight
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 13'd1100; in_mant = 64'h8000_0000_0000_0000;
        tick();
        in_exp = 13'd1101;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_flight_ov", out_valid, 0);
        chk("rst_flight_data", out_data, 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) cnt++;
            tick();
        end
        chk("rst_flight_gone", 64'(cnt), 64'd0);

        run_vec("post_rst", 0, 13'd1024, 64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
